// File: rtl/collision_monitor.sv
// collision_monitor
// Watches the frog square against the pixel rows of every hazard lane.
// On a collision it costs a life and asks the frog controller for a respawn,
// then masks further collisions for a grace window. When the last life is
// lost it raises hit/game_over, which freezes the lanes until a restart.
module collision_monitor #(
    parameter int LANES        = 5,
    parameter int LANE_BASE    = 1,
    parameter int LIVES        = 3,
    parameter int GRACE_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [16*LANES-1:0]  lane_pixels,
    input  logic [3:0]           frog_row,
    input  logic [3:0]           frog_col,
    input  logic                 start,
    output logic                 hit,
    output logic                 respawn,
    output logic [1:0]           lives,
    output logic                 game_over
);

    // Counter wide enough to hold GRACE_CYCLES-1
    localparam int GW = (GRACE_CYCLES > 2) ? $clog2(GRACE_CYCLES) : 1;
    localparam logic [GW-1:0] GRACE_LOAD = GW'(GRACE_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_GRACE = 2'd1,
        S_OVER  = 2'd2
    } state_e;

    state_e          state_q;
    logic [1:0]      lives_q;
    logic [GW-1:0]   grace_q;
    logic            respawn_q;
    logic            hit_q;
    logic            game_over_q;

    logic [LANES-1:0] lane_hit;
    logic             overlap;

    // One comparator per lane: the frog is on this lane's row and the pixel
    // under its column is lit. Column 0 maps to bit 15 of the lane row.
    // Rows outside the lane band match no lane, so they never overlap.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [15:0] row_w;
            logic        on_row_w;
            assign row_w        = lane_pixels[16*gi +: 16];
            assign on_row_w     = ({1'b0, frog_row} == 5'(LANE_BASE + gi));
            assign lane_hit[gi] = on_row_w && row_w[4'd15 - frog_col];
        end
    endgenerate

    assign overlap = |lane_hit;

    // Game FSM with all outputs registered; respawn is a single-cycle pulse
    // because it is cleared every cycle unless a transition into GRACE fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_PLAY;
            lives_q     <= LIVES_INIT;
            grace_q     <= '0;
            respawn_q   <= 1'b0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            respawn_q <= 1'b0;
            case (state_q)
                S_PLAY: begin
                    if (overlap) begin
                        if (lives_q > 2'd1) begin
                            lives_q   <= lives_q - 2'd1;
                            respawn_q <= 1'b1;
                            grace_q   <= GRACE_LOAD;
                            state_q   <= S_GRACE;
                        end else begin
                            lives_q     <= 2'd0;
                            hit_q       <= 1'b1;
                            game_over_q <= 1'b1;
                            state_q     <= S_OVER;
                        end
                    end
                end
                S_GRACE: begin
                    // Collisions are ignored; the window lasts GRACE_CYCLES
                    // cycles counting the one where the counter sits at zero.
                    if (grace_q == '0) begin
                        state_q <= S_PLAY;
                    end else begin
                        grace_q <= grace_q - 1'b1;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        lives_q     <= LIVES_INIT;
                        hit_q       <= 1'b0;
                        game_over_q <= 1'b0;
                        respawn_q   <= 1'b1;
                        grace_q     <= GRACE_LOAD;
                        state_q     <= S_GRACE;
                    end
                end
                default: begin
                    state_q <= S_PLAY;
                end
            endcase
        end
    end

    assign hit       = hit_q;
    assign respawn   = respawn_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Scoreboard bench for collision_monitor: the driver updates a game-level
// reference model at every rising edge and queues the expected outputs; a
// separate monitor pops and compares on every falling edge.
module tb_collision_monitor;

    localparam int LANES        = 5;
    localparam int LANE_BASE    = 1;
    localparam int LIVES        = 3;
    localparam int GRACE_CYCLES = 64;

    logic                clk;
    logic                reset;
    logic [16*LANES-1:0] lane_pixels;
    logic [3:0]          frog_row;
    logic [3:0]          frog_col;
    logic                start;
    logic                hit;
    logic                respawn;
    logic [1:0]          lives;
    logic                game_over;

    collision_monitor #(
        .LANES(LANES), .LANE_BASE(LANE_BASE),
        .LIVES(LIVES), .GRACE_CYCLES(GRACE_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .lane_pixels(lane_pixels),
        .frog_row(frog_row), .frog_col(frog_col), .start(start),
        .hit(hit), .respawn(respawn), .lives(lives), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lives;
        bit resp;
        bit hit;
        bit go;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   txn    = 0;

    // Reference model: remaining lives, remaining grace cycles, game over flag
    int m_lives = LIVES;
    int m_grace = 0;
    bit m_over  = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic bit model_overlap();
        int k;
        k = int'(frog_row) - LANE_BASE;
        if (k < 0 || k >= LANES) return 1'b0;
        return lane_pixels[16*k + 15 - int'(frog_col)];
    endfunction

    // Advance one clock: model sees the same inputs the DUT samples
    task automatic step();
        exp_t e;
        bit   resp;
        @(posedge clk);
        resp = 1'b0;
        if (!reset) begin
            m_lives = LIVES; m_grace = 0; m_over = 1'b0;
        end else if (m_over) begin
            if (start) begin
                m_lives = LIVES; m_over = 1'b0; m_grace = GRACE_CYCLES; resp = 1'b1;
            end
        end else if (m_grace > 0) begin
            m_grace--;
        end else if (model_overlap()) begin
            if (m_lives > 1) begin
                m_lives--; m_grace = GRACE_CYCLES; resp = 1'b1;
            end else begin
                m_lives = 0; m_over = 1'b1;
            end
        end
        e.lives = m_lives; e.resp = resp; e.hit = m_over; e.go = m_over;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset asserted between edges, held for two edges, released between edges
    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        steps(2);
        reset = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d: lives=%0d respawn=%0b hit=%0b game_over=%0b (exp %0d %0b %0b %0b)",
                         txn, lives, respawn, hit, game_over, e.lives, e.resp, e.hit, e.go);
                chk("lives", int'(lives), e.lives);
                chk("respawn", int'(respawn), int'(e.resp));
                chk("hit", int'(hit), int'(e.hit));
                chk("game_over", int'(game_over), int'(e.go));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        lane_pixels = '0;
        lane_pixels[15:0] = 16'b1000110001100011;
        frog_row    = 4'd1;
        frog_col    = 4'd0;

        // Reset state, then frog parked on a lit pixel of lane 0
        steps(2);
        reset = 1'b1;
        steps(140);

        // Frog on an unlit pixel for 200 cycles
        do_reset();
        frog_col = 4'd1;
        steps(200);

        // Rows outside the lane band with every pixel lit
        lane_pixels = '1;
        frog_row = 4'd0;  steps(20);
        frog_row = 4'd6;  steps(20);
        frog_row = 4'd15; steps(5);

        // Last lane, last column
        lane_pixels = '0;
        lane_pixels[64] = 1'b1;
        frog_row = 4'd5; frog_col = 4'd15;
        steps(3);

        // Three separated collisions down to game over, held there
        do_reset();
        lane_pixels = '0;
        lane_pixels[15:0] = 16'b1000110001100011;
        frog_col = 4'd0;
        for (int n = 0; n < 3; n++) begin
            frog_row = 4'd1; step();
            frog_row = 4'd0; steps(80);
        end
        steps(30);

        // Restart with the frog on a hazard: grace masks it, then it bites
        frog_row = 4'd1;
        start = 1'b1; step();
        start = 1'b0; steps(70);

        // start ignored outside OVER
        do_reset();
        frog_row = 4'd0; start = 1'b1; steps(5);
        start = 1'b0;

        // Asynchronous reset in the middle of grace
        frog_row = 4'd1; step();
        frog_row = 4'd0; steps(10);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_lives", int'(lives), LIVES);
        chk("async_respawn", int'(respawn), 0);
        chk("async_hit", int'(hit), 0);
        chk("async_game_over", int'(game_over), 0);
        steps(2);
        reset = 1'b1;
        frog_row = 4'd1;
        steps(3);

        // Randomized play with sparse hazards and occasional restarts
        for (int i = 0; i < 2000; i++) begin
            for (int l = 0; l < LANES; l++)
                lane_pixels[16*l +: 16] = 16'($urandom & $urandom & $urandom);
            frog_row = 4'($urandom_range(0, 7));
            frog_col = 4'($urandom_range(0, 15));
            start    = ($urandom_range(0, 15) == 0);
            step();
        end
        start = 1'b0;

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
